// File: rtl/regbank_seq_ctrl.sv
// regbank_seq_ctrl: multi-cycle control sequencer for the 16x16 register
// bank and ALU. It accepts one 16-bit instruction per valid/ready handshake
// and walks IDLE -> DECODE -> EXEC -> WB. Illegal instructions skip EXEC.
// WB may accept the next instruction back-to-back.
//
// Optional build macro REGBANK_SEQ_RETIRE_CNT_EN adds a 16-bit retire_cnt
// output. The counter advances once per legal retirement and wraps.
module regbank_seq_ctrl #(
    parameter int NREGS = 16,
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             instr_valid,
    input  logic [15:0]      instr,
    output logic             instr_ready,
    output logic [3:0]       rd_sel_a,
    output logic [3:0]       rd_sel_b,
    output logic             imm_sel,
    output logic [WIDTH-1:0] imm_val,
    output logic [3:0]       alu_op,
    output logic [NREGS-1:0] reg_en,
    output logic             flag_we,
    output logic             done,
`ifdef REGBANK_SEQ_RETIRE_CNT_EN
    output logic             illegal,
    output logic [15:0]      retire_cnt
`else
    output logic             illegal
`endif
);

    localparam logic [3:0] ALU_ADD = 4'd0;
    localparam logic [3:0] ALU_SUB = 4'd1;
    localparam logic [3:0] ALU_CMP = 4'd2;
    localparam logic [3:0] ALU_AND = 4'd3;
    localparam logic [3:0] ALU_OR  = 4'd4;
    localparam logic [3:0] ALU_XOR = 4'd5;
    localparam logic [3:0] ALU_MOV = 4'd6;
    localparam logic [3:0] ALU_LUI = 4'd7;

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_DECODE = 2'd1,
        S_EXEC   = 2'd2,
        S_WB     = 2'd3
    } state_t;

    state_t             state_q;
    logic               instr_ready_q;
    logic [3:0]         rd_sel_a_q;
    logic [3:0]         rd_sel_b_q;
    logic               imm_sel_q;
    logic [WIDTH-1:0]   imm_val_q;
    logic [3:0]         alu_op_q;
    logic [NREGS-1:0]   reg_en_q;
    logic               flag_we_q;
    logic               done_q;
    logic               illegal_q;

    // Only the opcode and low byte are needed to decode. The register
    // fields go straight into the read-select registers.
    logic [3:0]         op_q;
    logic [7:0]         imm8_q;

    logic               accept;

    logic               legal_d;
    logic [3:0]         alu_op_d;
    logic               imm_sel_d;
    logic [WIDTH-1:0]   imm_val_d;
    logic               wr_en_d;
    logic               flag_we_d;

    // A handshake is possible only when instr_ready is high, which is only in IDLE or WB.
    assign accept = instr_valid && instr_ready_q;

    // Latch the fields of the accepted instruction that the decoder needs.
    always_ff @(posedge clk) begin
        if (accept) begin
            op_q   <= instr[15:12];
            imm8_q <= instr[7:0];
        end
    end

    // Decode the latched instruction into ALU controls and write-back intent.
    always_comb begin
        legal_d   = 1'b1;
        alu_op_d  = ALU_ADD;
        imm_sel_d = 1'b0;
        imm_val_d = '0;
        wr_en_d   = 1'b0;
        flag_we_d = 1'b0;
        if (op_q == 4'b0000) begin
            unique case (imm8_q[7:4])
                4'b0101: alu_op_d = ALU_ADD;
                4'b1001: alu_op_d = ALU_SUB;
                4'b1011: alu_op_d = ALU_CMP;
                4'b0001: alu_op_d = ALU_AND;
                4'b0010: alu_op_d = ALU_OR;
                4'b0011: alu_op_d = ALU_XOR;
                4'b1101: alu_op_d = ALU_MOV;
                default: legal_d  = 1'b0;
            endcase
        end else begin
            imm_sel_d = 1'b1;
            unique case (op_q)
                4'b0101: begin alu_op_d = ALU_ADD; imm_val_d = {{(WIDTH-8){imm8_q[7]}}, imm8_q}; end
                4'b1001: begin alu_op_d = ALU_SUB; imm_val_d = {{(WIDTH-8){imm8_q[7]}}, imm8_q}; end
                4'b1011: begin alu_op_d = ALU_CMP; imm_val_d = {{(WIDTH-8){imm8_q[7]}}, imm8_q}; end
                4'b1101: begin alu_op_d = ALU_MOV; imm_val_d = {{(WIDTH-8){imm8_q[7]}}, imm8_q}; end
                4'b0001: begin alu_op_d = ALU_AND; imm_val_d = {{(WIDTH-8){1'b0}}, imm8_q}; end
                4'b0010: begin alu_op_d = ALU_OR;  imm_val_d = {{(WIDTH-8){1'b0}}, imm8_q}; end
                4'b0011: begin alu_op_d = ALU_XOR; imm_val_d = {{(WIDTH-8){1'b0}}, imm8_q}; end
                4'b1111: begin alu_op_d = ALU_LUI; imm_val_d = {imm8_q, {(WIDTH-8){1'b0}}}; end
                default: begin legal_d = 1'b0; imm_sel_d = 1'b0; end
            endcase
        end
        if (legal_d) begin
            wr_en_d   = (alu_op_d != ALU_CMP);
            flag_we_d = (alu_op_d == ALU_ADD) || (alu_op_d == ALU_SUB) ||
                        (alu_op_d == ALU_CMP);
        end
    end

    // Sequencer FSM. Every output is a register that is updated here.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q       <= S_IDLE;
            instr_ready_q <= 1'b0;
            rd_sel_a_q    <= '0;
            rd_sel_b_q    <= '0;
            imm_sel_q     <= 1'b0;
            imm_val_q     <= '0;
            alu_op_q      <= '0;
            reg_en_q      <= '0;
            flag_we_q     <= 1'b0;
            done_q        <= 1'b0;
            illegal_q     <= 1'b0;
        end else begin
            unique case (state_q)
                S_IDLE: begin
                    instr_ready_q <= 1'b1;
                    if (accept) begin
                        rd_sel_a_q    <= instr[11:8];
                        rd_sel_b_q    <= instr[3:0];
                        instr_ready_q <= 1'b0;
                        state_q       <= S_DECODE;
                    end
                end
                S_DECODE: begin
                    if (legal_d) begin
                        alu_op_q  <= alu_op_d;
                        imm_sel_q <= imm_sel_d;
                        imm_val_q <= imm_val_d;
                        state_q   <= S_EXEC;
                    end else begin
                        // Undecodable: go straight to WB with no write and no flags.
                        alu_op_q      <= '0;
                        imm_sel_q     <= 1'b0;
                        imm_val_q     <= '0;
                        reg_en_q      <= '0;
                        flag_we_q     <= 1'b0;
                        illegal_q     <= 1'b1;
                        done_q        <= 1'b1;
                        instr_ready_q <= 1'b1;
                        state_q       <= S_WB;
                    end
                end
                S_EXEC: begin
                    reg_en_q      <= wr_en_d ? (NREGS'(1) << rd_sel_a_q) : '0;
                    flag_we_q     <= flag_we_d;
                    done_q        <= 1'b1;
                    illegal_q     <= 1'b0;
                    instr_ready_q <= 1'b1;
                    state_q       <= S_WB;
                end
                S_WB: begin
                    reg_en_q  <= '0;
                    flag_we_q <= 1'b0;
                    done_q    <= 1'b0;
                    illegal_q <= 1'b0;
                    if (accept) begin
                        rd_sel_a_q    <= instr[11:8];
                        rd_sel_b_q    <= instr[3:0];
                        instr_ready_q <= 1'b0;
                        state_q       <= S_DECODE;
                    end else begin
                        state_q <= S_IDLE;
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

`ifdef REGBANK_SEQ_RETIRE_CNT_EN
    logic [15:0] retire_cnt_q;

    // Count legal retirements. The counter advances as the done pulse ends and wraps naturally.
    always_ff @(posedge clk) begin
        if (reset) begin
            retire_cnt_q <= '0;
        end else if (done_q && !illegal_q) begin
            retire_cnt_q <= retire_cnt_q + 16'd1;
        end
    end

    assign retire_cnt = retire_cnt_q;
`endif

    assign instr_ready = instr_ready_q;
    assign rd_sel_a    = rd_sel_a_q;
    assign rd_sel_b    = rd_sel_b_q;
    assign imm_sel     = imm_sel_q;
    assign imm_val     = imm_val_q;
    assign alu_op      = alu_op_q;
    assign reg_en      = reg_en_q;
    assign flag_we     = flag_we_q;
    assign done        = done_q;
    assign illegal     = illegal_q;

endmodule

// File: tb/tb_regbank_seq_ctrl.sv
// Directed testbench for regbank_seq_ctrl. It covers reset and idle, a
// register-form ADD, an immediate decode table, back-to-back issue, illegal
// instructions and reset in the middle of an operation.
module tb_regbank_seq_ctrl;

    logic        clk = 1'b0;
    logic        reset;
    logic        instr_valid;
    logic [15:0] instr;
    logic        instr_ready;
    logic [3:0]  rd_sel_a;
    logic [3:0]  rd_sel_b;
    logic        imm_sel;
    logic [15:0] imm_val;
    logic [3:0]  alu_op;
    logic [15:0] reg_en;
    logic        flag_we;
    logic        done;
    logic        illegal;
`ifdef REGBANK_SEQ_RETIRE_CNT_EN
    logic [15:0] retire_cnt;
`endif

    int n_checks = 0;
    int n_pass   = 0;

    regbank_seq_ctrl #(.NREGS(16), .WIDTH(16)) dut (
        .clk         (clk),
        .reset       (reset),
        .instr_valid (instr_valid),
        .instr       (instr),
        .instr_ready (instr_ready),
        .rd_sel_a    (rd_sel_a),
        .rd_sel_b    (rd_sel_b),
        .imm_sel     (imm_sel),
        .imm_val     (imm_val),
        .alu_op      (alu_op),
        .reg_en      (reg_en),
        .flag_we     (flag_we),
        .done        (done),
`ifdef REGBANK_SEQ_RETIRE_CNT_EN
        .illegal     (illegal),
        .retire_cnt  (retire_cnt)
`else
        .illegal     (illegal)
`endif
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Bounded wait for instr_ready. The result is reported to the caller.
    task automatic wait_ready(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 20; i++) begin
            if (instr_ready === 1'b1) begin
                ok = 1'b1;
                break;
            end
            tick();
        end
    endtask

    task automatic test_reset();
        logic [42:0] obs;
        reset = 1'b1; instr_valid = 1'b0; instr = 16'h0000;
        tick(); tick();
        n_checks++;
        obs = {instr_ready, reg_en, done, flag_we, illegal, rd_sel_a, rd_sel_b, alu_op, imm_sel};
        if (obs !== 43'd0) $display("FAIL reset_values: got %h want 0", obs);
        else n_pass++;
        reset = 1'b0;
        tick();
        n_checks++;
        if (instr_ready !== 1'b1) $display("FAIL ready_after_reset: got %b want 1", instr_ready);
        else n_pass++;
        for (int c = 0; c < 10; c++) begin
            tick();
            n_checks++;
            if ({instr_ready, reg_en, done, flag_we, illegal, imm_val} !== {1'b1, 16'h0, 3'b000, 16'h0})
                $display("FAIL idle_hold[%0d]: ready=%b reg_en=%h done=%b flag_we=%b illegal=%b imm_val=%h want 1/0000/0/0/0/0000",
                         c, instr_ready, reg_en, done, flag_we, illegal, imm_val);
            else n_pass++;
        end
    endtask

    task automatic test_reg_add();
        bit ok;
`ifdef REGBANK_SEQ_RETIRE_CNT_EN
        logic [15:0] cnt0;
        cnt0 = retire_cnt;
`endif
        wait_ready(ok);
        n_checks++;
        if (!ok) $display("FAIL add_ready_timeout: got ready=%b want 1", instr_ready);
        else n_pass++;
        instr_valid = 1'b1; instr = 16'h0352;
        tick();                                    // DECODE
        instr_valid = 1'b0;
        n_checks++;
        if ({rd_sel_a, rd_sel_b, instr_ready} !== {4'd3, 4'd2, 1'b0})
            $display("FAIL add_decode: got a=%0d b=%0d ready=%b want a=3 b=2 ready=0", rd_sel_a, rd_sel_b, instr_ready);
        else n_pass++;
        tick();                                    // EXEC
        n_checks++;
        if ({alu_op, imm_sel, done, reg_en} !== {4'd0, 1'b0, 1'b0, 16'h0})
            $display("FAIL add_exec: got alu_op=%0d imm_sel=%b done=%b reg_en=%h want 0/0/0/0000", alu_op, imm_sel, done, reg_en);
        else n_pass++;
        tick();                                    // WB at N+3
        n_checks++;
        if ({reg_en, flag_we, done, illegal, instr_ready, rd_sel_a, alu_op} !== {16'h0008, 1'b1, 1'b1, 1'b0, 1'b1, 4'd3, 4'd0})
            $display("FAIL add_wb: got reg_en=%h flag_we=%b done=%b illegal=%b ready=%b a=%0d alu=%0d want 0008/1/1/0/1/3/0",
                     reg_en, flag_we, done, illegal, instr_ready, rd_sel_a, alu_op);
        else n_pass++;
        tick();                                    // IDLE
        n_checks++;
        if ({reg_en, flag_we, done, instr_ready} !== {16'h0, 1'b0, 1'b0, 1'b1})
            $display("FAIL add_after_wb: got reg_en=%h flag_we=%b done=%b ready=%b want 0000/0/0/1", reg_en, flag_we, done, instr_ready);
        else n_pass++;
`ifdef REGBANK_SEQ_RETIRE_CNT_EN
        n_checks++;
        if (retire_cnt !== cnt0 + 16'd1) $display("FAIL add_retire_cnt: got %h want %h", retire_cnt, cnt0 + 16'd1);
        else n_pass++;
`endif
    endtask

    task automatic test_immediates();
        // Each vector: instr, rd_a, alu_op, imm_sel, imm_val, reg_en, flag_we
        logic [15:0] v_instr [7] = '{16'h57F0, 16'h1AF0, 16'hF412, 16'hB205, 16'h9380, 16'h3C81, 16'h05D5};
        logic [3:0]  v_rda   [7] = '{4'd7, 4'hA, 4'd4, 4'd2, 4'd3, 4'hC, 4'd5};
        logic [3:0]  v_alu   [7] = '{4'd0, 4'd3, 4'd7, 4'd2, 4'd1, 4'd5, 4'd6};
        logic        v_isel  [7] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
        logic [15:0] v_imm   [7] = '{16'hFFF0, 16'h00F0, 16'h1200, 16'h0005, 16'hFF80, 16'h0081, 16'h0000};
        logic [15:0] v_regen [7] = '{16'h0080, 16'h0400, 16'h0010, 16'h0000, 16'h0008, 16'h1000, 16'h0020};
        logic        v_flag  [7] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
        bit ok;
        for (int i = 0; i < 7; i++) begin
            wait_ready(ok);
            if (!ok) begin
                n_checks++;
                $display("FAIL imm_ready_timeout[%0d]: got ready=%b want 1", i, instr_ready);
                continue;
            end
            instr_valid = 1'b1; instr = v_instr[i];
            tick();                                // DECODE
            instr_valid = 1'b0;
            tick();                                // EXEC
            n_checks++;
            if ({rd_sel_a, alu_op, imm_sel, imm_val} !== {v_rda[i], v_alu[i], v_isel[i], v_imm[i]})
                $display("FAIL imm_exec[%h]: got a=%h alu=%0d imm_sel=%b imm_val=%h want a=%h alu=%0d imm_sel=%b imm_val=%h",
                         v_instr[i], rd_sel_a, alu_op, imm_sel, imm_val, v_rda[i], v_alu[i], v_isel[i], v_imm[i]);
            else n_pass++;
            tick();                                // WB
            n_checks++;
            if ({reg_en, flag_we, done, illegal, imm_val} !== {v_regen[i], v_flag[i], 1'b1, 1'b0, v_imm[i]})
                $display("FAIL imm_wb[%h]: got reg_en=%h flag_we=%b done=%b illegal=%b imm_val=%h want %h/%b/1/0/%h",
                         v_instr[i], reg_en, flag_we, done, illegal, imm_val, v_regen[i], v_flag[i], v_imm[i]);
            else n_pass++;
            tick();                                // IDLE
        end
    endtask

    task automatic test_back_to_back();
        logic [15:0] seq [3] = '{16'h0352, 16'h25AB, 16'h01D7};
        logic [15:0] wben [3] = '{16'h0008, 16'h0020, 16'h0002};
        logic [3:0]  rda  [3] = '{4'd3, 4'd5, 4'd1};
        bit ok;
        wait_ready(ok);
        n_checks++;
        if (!ok) $display("FAIL b2b_ready_timeout: got ready=%b want 1", instr_ready);
        else n_pass++;
        instr_valid = 1'b1; instr = seq[0];
        for (int k = 1; k <= 10; k++) begin
            tick();
            // Present the next instruction once the current one is in DECODE.
            if (k == 1) instr = seq[1];
            if (k == 4) instr = seq[2];
            if (k == 7) instr_valid = 1'b0;
            n_checks++;
            if (k == 3 || k == 6 || k == 9) begin
                if ({done, instr_ready, reg_en} !== {1'b1, 1'b1, wben[k/3-1]})
                    $display("FAIL b2b_wb[k=%0d]: got done=%b ready=%b reg_en=%h want 1/1/%h", k, done, instr_ready, reg_en, wben[k/3-1]);
                else n_pass++;
            end else if (k == 10) begin
                if ({done, instr_ready, reg_en} !== {1'b0, 1'b1, 16'h0})
                    $display("FAIL b2b_idle[k=%0d]: got done=%b ready=%b reg_en=%h want 0/1/0000", k, done, instr_ready, reg_en);
                else n_pass++;
            end else if (k == 1 || k == 4 || k == 7) begin
                if ({done, instr_ready, rd_sel_a} !== {1'b0, 1'b0, rda[k/3]})
                    $display("FAIL b2b_decode[k=%0d]: got done=%b ready=%b a=%h want 0/0/%h", k, done, instr_ready, rd_sel_a, rda[k/3]);
                else n_pass++;
            end else begin
                if ({done, instr_ready} !== 2'b00)
                    $display("FAIL b2b_busy[k=%0d]: got done=%b ready=%b want 0/0", k, done, instr_ready);
                else n_pass++;
            end
        end
    endtask

    task automatic test_illegal();
        logic [15:0] bad [2] = '{16'h0E40, 16'h4123};
        bit ok;
`ifdef REGBANK_SEQ_RETIRE_CNT_EN
        logic [15:0] cnt0;
`endif
        for (int i = 0; i < 2; i++) begin
            wait_ready(ok);
            if (!ok) begin
                n_checks++;
                $display("FAIL ill_ready_timeout[%0d]: got ready=%b want 1", i, instr_ready);
                continue;
            end
`ifdef REGBANK_SEQ_RETIRE_CNT_EN
            cnt0 = retire_cnt;
`endif
            instr_valid = 1'b1; instr = bad[i];
            tick();                                // DECODE
            instr_valid = 1'b0;
            tick();                                // WB, EXEC skipped
            n_checks++;
            if ({illegal, done, reg_en, flag_we, instr_ready} !== {1'b1, 1'b1, 16'h0, 1'b0, 1'b1})
                $display("FAIL ill_wb[%h]: got illegal=%b done=%b reg_en=%h flag_we=%b ready=%b want 1/1/0000/0/1",
                         bad[i], illegal, done, reg_en, flag_we, instr_ready);
            else n_pass++;
            tick();                                // IDLE
            n_checks++;
            if ({illegal, done} !== 2'b00)
                $display("FAIL ill_after[%h]: got illegal=%b done=%b want 0/0", bad[i], illegal, done);
            else n_pass++;
`ifdef REGBANK_SEQ_RETIRE_CNT_EN
            n_checks++;
            if (retire_cnt !== cnt0) $display("FAIL ill_retire_cnt[%h]: got %h want %h", bad[i], retire_cnt, cnt0);
            else n_pass++;
`endif
        end
    endtask

    task automatic test_reset_mid_op();
        bit ok;
        bit saw_done;
        bit saw_wr;
        wait_ready(ok);
        n_checks++;
        if (!ok) $display("FAIL mid_ready_timeout: got ready=%b want 1", instr_ready);
        else n_pass++;
        instr_valid = 1'b1; instr = 16'h0352;
        tick();                                    // DECODE
        instr_valid = 1'b0;
        tick();                                    // EXEC
        reset = 1'b1;
        tick();                                    // forced IDLE
        reset = 1'b0;
        n_checks++;
        if ({reg_en, done, flag_we, instr_ready} !== {16'h0, 1'b0, 1'b0, 1'b0})
            $display("FAIL mid_reset_state: got reg_en=%h done=%b flag_we=%b ready=%b want 0000/0/0/0", reg_en, done, flag_we, instr_ready);
        else n_pass++;
        saw_done = 1'b0; saw_wr = 1'b0;
        for (int c = 0; c < 6; c++) begin
            tick();
            if (done) saw_done = 1'b1;
            if (reg_en != 16'h0) saw_wr = 1'b1;
        end
        n_checks++;
        if ({saw_done, saw_wr, instr_ready} !== 3'b001)
            $display("FAIL mid_no_retire: got saw_done=%b saw_wr=%b ready=%b want 0/0/1", saw_done, saw_wr, instr_ready);
        else n_pass++;
    endtask

    initial begin
        reset = 1'b1; instr_valid = 1'b0; instr = 16'h0000;
        test_reset();
        test_reg_add();
        test_immediates();
        test_back_to_back();
        test_illegal();
        test_reset_mid_op();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
